// File: rtl/npc_pkg.sv
// Shared encodings for the next-PC unit: branch conditions, next-PC source
// selector and exception FSM states.
package npc_pkg;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LEZ = 3'd2;
  localparam logic [2:0] BR_GTZ = 3'd3;
  localparam logic [2:0] BR_LTZ = 3'd4;
  localparam logic [2:0] BR_GEZ = 3'd5;

  // SRC_HOLD is the stalled case, where the PC keeps its value
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_J    = 3'd2,
    SRC_JR   = 3'd3,
    SRC_EXC  = 3'd4,
    SRC_ERET = 3'd5,
    SRC_HOLD = 3'd6
  } npc_src_e;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } exc_state_e;

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry. A pop on an empty stack does nothing.
module npc_ras
  import npc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         top,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW:0]      r_count;
  logic [PW-1:0]    w_top_idx;

  // r_wp points at the next free slot, so the top entry sits one below it
  assign w_top_idx = r_wp - PW'(1);
  assign empty     = (r_count == (PW+1)'(0));
  assign count     = r_count;
  assign top       = empty ? {WIDTH{1'b0}} : r_mem[w_top_idx];

  // Stack storage, write pointer and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wp    <= {PW{1'b0}};
      r_count <= {(PW+1){1'b0}};
    end else if (push) begin
      r_mem[r_wp] <= push_data;
      r_wp        <= r_wp + PW'(1);
      if (r_count != FULL) begin
        r_count <= r_count + (PW+1)'(1);
      end else begin
        r_count <= r_count;
      end
    end else if (pop && !empty) begin
      r_wp    <= r_wp - PW'(1);
      r_count <= r_count - (PW+1)'(1);
    end else begin
      r_wp    <= r_wp;
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/npc_unit.sv
// Next-PC unit: architectural PC, branch/jump/jr/exception source selection,
// EPC, a two-state exception FSM and a return-address stack for jal/jr-ra.
module npc_unit
  import npc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_0080,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic [2:0]       br_cond,
  input  logic             zero,
  input  logic             neg,
  input  logic             jump,
  input  logic             link,
  input  logic             jr,
  input  logic             jr_is_ret,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] imm32,
  input  logic [25:0]      imm26,
  input  logic             exc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             in_handler,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_mismatch
);

  localparam int               CW     = $clog2(RAS_DEPTH) + 1;
  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(4);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  exc_state_e       r_state;
  logic             r_mismatch;

  npc_src_e         w_src;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_j_target;
  logic             w_exc_take;
  logic             w_eret_take;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic [CW-1:0]    w_ras_count;

  function automatic logic br_taken(input logic [2:0] cond, input logic z, input logic n);
    case (cond)
      BR_EQ:   br_taken = z;
      BR_NE:   br_taken = !z;
      BR_LEZ:  br_taken = z | n;
      BR_GTZ:  br_taken = !z & !n;
      BR_LTZ:  br_taken = n;
      BR_GEZ:  br_taken = !n;
      default: br_taken = 1'b0;
    endcase
  endfunction

  assign pc_plus4     = r_pc + PC_INC;
  assign pc           = r_pc;
  assign epc          = r_epc;
  assign in_handler   = (r_state == ST_HANDLER);
  assign ras_top      = w_ras_top;
  assign ras_empty    = w_ras_empty;
  assign ras_mismatch = r_mismatch;

  // Source selection; an eret outside the handler degrades to sequential
  always_comb begin
    w_exc_take  = exc && (r_state == ST_NORMAL);
    w_eret_take = eret && (r_state == ST_HANDLER);
    w_j_target  = r_pc;
    w_j_target[27:0] = {imm26, 2'b00};
    if (w_exc_take) begin
      w_src = SRC_EXC;
    end else if (eret) begin
      if (w_eret_take) begin
        w_src = SRC_ERET;
      end else begin
        w_src = SRC_SEQ;
      end
    end else if (stall) begin
      w_src = SRC_HOLD;
    end else if (jr) begin
      w_src = SRC_JR;
    end else if (branch && br_taken(br_cond, zero, neg)) begin
      w_src = SRC_BR;
    end else if (jump) begin
      w_src = SRC_J;
    end else begin
      w_src = SRC_SEQ;
    end
    case (w_src)
      SRC_EXC:  w_next_pc = EXC_VEC;
      SRC_ERET: w_next_pc = r_epc;
      SRC_HOLD: w_next_pc = r_pc;
      SRC_JR:   w_next_pc = jr_target;
      SRC_BR:   w_next_pc = pc_plus4 + imm32;
      SRC_J:    w_next_pc = w_j_target;
      default:  w_next_pc = pc_plus4;
    endcase
    w_push = (w_src == SRC_J) && link;
    w_pop  = (w_src == SRC_JR) && jr_is_ret && (w_ras_count != CW'(0));
  end

  npc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (pc_plus4),
    .pop       (w_pop),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .count     (w_ras_count)
  );

  // PC, EPC, exception FSM and the return-prediction mismatch pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_VEC;
      r_epc      <= {WIDTH{1'b0}};
      r_state    <= ST_NORMAL;
      r_mismatch <= 1'b0;
    end else begin
      r_pc       <= w_next_pc;
      r_mismatch <= w_pop && (w_ras_top != jr_target);
      if (w_src == SRC_EXC) begin
        r_epc   <= r_pc;
        r_state <= ST_HANDLER;
      end else if (w_src == SRC_ERET) begin
        r_epc   <= r_epc;
        r_state <= ST_NORMAL;
      end else begin
        r_epc   <= r_epc;
        r_state <= r_state;
      end
    end
  end

endmodule
